fixed_divider_param: RTL and testbench

- Parametrised multi-cycle fixed-point divider; next generation of the 10-bit sequential divider used in the CA datapaths.
- Computes Q = (A * 2^FRAC) / B with configurable width and fraction bits.
- Adds a remainder output and a per-operation signed/unsigned mode; keeps the start/busy/valid handshake and the dvz/ovf flags.
- One quotient bit per cycle, restoring algorithm. The datapath and controller FSM live in one module.

---
 rtl/fixed_divider_param.sv | 181 ++++++++++++++++++
 tb/tb_fixed_divider_param.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_divider_param.sv
// Parametrised multi-cycle fixed-point divider: Q = (A * 2^FRAC) / B.
// Restoring algorithm, one quotient bit per cycle, with signed/unsigned mode,
// remainder output, divide-by-zero and saturating overflow flags.
module fixed_divider_param #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FRAC  = 4
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] q_out,
    output logic [WIDTH-1:0] r_out,
    output logic             dvz,
    output logic             ovf,
    output logic             busy,
    output logic             valid
);

    localparam int unsigned N  = WIDTH + FRAC;
    localparam int unsigned RW = WIDTH + 1;
    localparam int unsigned CW = $clog2(N);

    // Saturation limits expressed on the full (N+1)-bit quotient magnitude
    localparam logic [N:0] MAX_U   = {{(FRAC + 1){1'b0}}, {WIDTH{1'b1}}};
    localparam logic [N:0] MAX_POS = {{(FRAC + 2){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic [N:0] MAX_NEG = MAX_POS + 1'b1;

    typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               mode_q, mode_d;
    logic [N-1:0]       dvd_q, dvd_d;
    logic [WIDTH-1:0]   bmag_q, bmag_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   q_q, q_d, r_q, r_d;
    logic               dvz_q, dvz_d, ovf_q, ovf_d, busy_q, busy_d, valid_q, valid_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH+1:0]   trial;
    logic               step_ge;
    logic [WIDTH:0]     rem_step;
    logic [N-1:0]       dvd_step;
    logic [N:0]         qext;
    logic               neg_res, ovf_res;
    logic [WIDTH-1:0]   q_res, r_res;

    // Operand magnitudes, one restoring step, and result formatting of that step
    always_comb begin
        abs_a    = (mode_q && a_q[WIDTH-1]) ? -a_q : a_q;
        abs_b    = (mode_q && b_q[WIDTH-1]) ? -b_q : b_q;
        trial    = {rem_q, dvd_q[N-1]};
        step_ge  = trial >= {2'b00, bmag_q};
        rem_step = step_ge ? RW'(trial - {2'b00, bmag_q}) : RW'(trial);
        dvd_step = {dvd_q[N-2:0], step_ge};
        qext     = {1'b0, dvd_step};
        neg_res  = mode_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]) && (dvd_step != '0);
        if (!mode_q) begin
            ovf_res = qext > MAX_U;
            q_res   = ovf_res ? '1 : WIDTH'(dvd_step);
            r_res   = WIDTH'(rem_step);
        end else begin
            ovf_res = neg_res ? (qext > MAX_NEG) : (qext > MAX_POS);
            if (ovf_res)
                q_res = neg_res ? {1'b1, {(WIDTH - 1){1'b0}}} : {1'b0, {(WIDTH - 1){1'b1}}};
            else
                q_res = neg_res ? WIDTH'(-dvd_step) : WIDTH'(dvd_step);
            r_res   = a_q[WIDTH-1] ? WIDTH'(-rem_step) : WIDTH'(rem_step);
        end
    end

    // Controller next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        dvd_d   = dvd_q;
        bmag_d  = bmag_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dvz_d   = dvz_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    mode_d  = signed_mode;
                    dvz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abs_b == '0) begin
                    q_d     = '0;
                    r_d     = '0;
                    dvz_d   = 1'b1;
                    ovf_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = DONE;
                end else begin
                    dvd_d   = N'(abs_a) << FRAC;
                    bmag_d  = abs_b;
                    rem_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ITER;
                end
            end
            ITER: begin
                dvd_d = dvd_step;
                rem_d = rem_step;
                cnt_d = cnt_q + CW'(1);
                // Final step: results are formatted straight from this step's outputs
                if (cnt_q == CW'(N - 1)) begin
                    q_d     = q_res;
                    r_d     = r_res;
                    ovf_d   = ovf_res;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous clear
    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            dvd_q   <= '0;
            bmag_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dvz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            dvd_q   <= dvd_d;
            bmag_q  <= bmag_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dvz_q   <= dvz_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign q_out = q_q;
    assign r_out = r_q;
    assign dvz   = dvz_q;
    assign ovf   = ovf_q;
    assign busy  = busy_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_fixed_divider_param.sv
// Directed-vector bench for fixed_divider_param (16.4 instance) plus
// FRAC=0 and FRAC=WIDTH instances swept against a behavioural model.
module tb_fixed_divider_param;

    localparam int W = 16;
    localparam int F = 4;
    localparam int N = W + F;

    logic         clk = 1'b0;
    logic         sclr, start, sm;
    logic [W-1:0] a, b, q, r;
    logic         dvz, ovf, busy, valid;

    logic         s_start, s_sm;
    logic [7:0]   s_a, s_b, q0, r0, q8, r8;
    logic         dvz0, ovf0, busy0, valid0, dvz8, ovf8, busy8, valid8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fixed_divider_param #(.WIDTH(W), .FRAC(F)) u_dut (
        .clk(clk), .sclr(sclr), .start(start), .signed_mode(sm), .a_in(a), .b_in(b),
        .q_out(q), .r_out(r), .dvz(dvz), .ovf(ovf), .busy(busy), .valid(valid));

    fixed_divider_param #(.WIDTH(8), .FRAC(0)) u_f0 (
        .clk(clk), .sclr(sclr), .start(s_start), .signed_mode(s_sm), .a_in(s_a), .b_in(s_b),
        .q_out(q0), .r_out(r0), .dvz(dvz0), .ovf(ovf0), .busy(busy0), .valid(valid0));

    fixed_divider_param #(.WIDTH(8), .FRAC(8)) u_f8 (
        .clk(clk), .sclr(sclr), .start(s_start), .signed_mode(s_sm), .a_in(s_a), .b_in(s_b),
        .q_out(q8), .r_out(r8), .dvz(dvz8), .ovf(ovf8), .busy(busy8), .valid(valid8));

    typedef struct {
        logic         sm;
        logic [W-1:0] a, b, q, r;
        logic         dvz, ovf;
    } vec_t;

    vec_t tv[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: plain integer division, truncating toward zero
    function automatic void ref_div(input int w, input int f, input bit smv,
                                    input longint av, input longint bv,
                                    output longint qv, output longint rv,
                                    output bit dz, output bit ov);
        longint as, bs, num, qf, rf, mask;
        mask = (longint'(1) << w) - 1;
        qv = 0; rv = 0; dz = 0; ov = 0;
        if (bv == 0) begin
            dz = 1;
            return;
        end
        as = av; bs = bv;
        if (smv) begin
            if (av >= (longint'(1) << (w - 1))) as = av - (longint'(1) << w);
            if (bv >= (longint'(1) << (w - 1))) bs = bv - (longint'(1) << w);
        end
        num = as * (longint'(1) << f);
        qf  = num / bs;
        rf  = num % bs;
        if (!smv) begin
            if (qf > mask) begin ov = 1; qf = mask; end
        end else if (qf > (longint'(1) << (w - 1)) - 1) begin
            ov = 1; qf = (longint'(1) << (w - 1)) - 1;
        end else if (qf < -(longint'(1) << (w - 1))) begin
            ov = 1; qf = -(longint'(1) << (w - 1));
        end
        qv = qf & mask;
        rv = rf & mask;
    endfunction

    task automatic run_op(input string tag, input vec_t v, input logic [W-1:0] prev_q);
        int lat;
        bit busy_bad;
        bit exp_busy;
        start = 1'b1; sm = v.sm; a = v.a; b = v.b;
        tick();
        start = 1'b0; a = W'($urandom); b = W'($urandom);
        chk({tag, " hold_q"}, q, prev_q);
        chk({tag, " dvz_clr"}, dvz, 0);
        chk({tag, " ovf_clr"}, ovf, 0);
        lat = 0; busy_bad = 0;
        while (lat < 40) begin
            tick();
            lat++;
            if (valid) break;
            exp_busy = (v.b != 0) && (lat <= N);
            if (busy !== exp_busy) busy_bad = 1;
        end
        chk({tag, " latency"}, lat, (v.b == 0) ? 1 : N + 1);
        chk({tag, " busy_pattern"}, busy_bad, 0);
        chk({tag, " busy_at_valid"}, busy, 0);
        chk({tag, " q"}, q, v.q);
        chk({tag, " r"}, r, v.r);
        chk({tag, " dvz"}, dvz, v.dvz);
        chk({tag, " ovf"}, ovf, v.ovf);
    endtask

    task automatic sweep_op(input int idx, input bit smv, input logic [7:0] av, input logic [7:0] bv);
        longint eq0, er0, eq8, er8;
        bit ed0, eo0, ed8, eo8;
        int lat, l0, l8;
        logic [7:0] gq0, gr0, gq8, gr8;
        logic gd0, go0, gd8, go8;
        string t;
        ref_div(8, 0, smv, longint'(av), longint'(bv), eq0, er0, ed0, eo0);
        ref_div(8, 8, smv, longint'(av), longint'(bv), eq8, er8, ed8, eo8);
        s_start = 1'b1; s_sm = smv; s_a = av; s_b = bv;
        tick();
        s_start = 1'b0;
        lat = 0; l0 = 0; l8 = 0;
        gq0 = 'x; gr0 = 'x; gd0 = 'x; go0 = 'x;
        gq8 = 'x; gr8 = 'x; gd8 = 'x; go8 = 'x;
        while (lat < 30 && (l0 == 0 || l8 == 0)) begin
            tick();
            lat++;
            if (valid0 && l0 == 0) begin l0 = lat; gq0 = q0; gr0 = r0; gd0 = dvz0; go0 = ovf0; end
            if (valid8 && l8 == 0) begin l8 = lat; gq8 = q8; gr8 = r8; gd8 = dvz8; go8 = ovf8; end
        end
        t = $sformatf("sweep%0d s=%0d a=%0h b=%0h", idx, smv, av, bv);
        chk({t, " f0 lat"}, l0, (bv == 0) ? 1 : 9);
        chk({t, " f0 q"}, gq0, eq0);
        chk({t, " f0 r"}, gr0, er0);
        chk({t, " f0 dvz"}, gd0, ed0);
        chk({t, " f0 ovf"}, go0, eo0);
        chk({t, " f8 lat"}, l8, (bv == 0) ? 1 : 17);
        chk({t, " f8 q"}, gq8, eq8);
        chk({t, " f8 r"}, gr8, er8);
        chk({t, " f8 dvz"}, gd8, ed8);
        chk({t, " f8 ovf"}, go8, eo8);
    endtask

    initial begin
        int lat;
        bit seen;
        vec_t v;

        tv[0]  = '{1'b0, 16'd100,  16'd8,    16'h00C8, 16'h0000, 1'b0, 1'b0};
        tv[1]  = '{1'b0, 16'd7,    16'd3,    16'd37,   16'd1,    1'b0, 1'b0};
        tv[2]  = '{1'b0, 16'hFFFF, 16'd1,    16'hFFFF, 16'h0000, 1'b0, 1'b1};
        tv[3]  = '{1'b0, 16'd1234, 16'd0,    16'h0000, 16'h0000, 1'b1, 1'b0};
        tv[4]  = '{1'b1, 16'hFF9C, 16'd8,    16'hFF38, 16'h0000, 1'b0, 1'b0};
        tv[5]  = '{1'b1, 16'hFFF9, 16'd3,    16'hFFDB, 16'hFFFF, 1'b0, 1'b0};
        tv[6]  = '{1'b1, 16'h8000, 16'd1,    16'h8000, 16'h0000, 1'b0, 1'b1};
        tv[7]  = '{1'b1, 16'h7FFF, 16'd1,    16'h7FFF, 16'h0000, 1'b0, 1'b1};
        tv[8]  = '{1'b1, 16'h8000, 16'd0,    16'h0000, 16'h0000, 1'b1, 1'b0};
        tv[9]  = '{1'b1, 16'h0064, 16'hFFF8, 16'hFF38, 16'h0000, 1'b0, 1'b0};
        tv[10] = '{1'b1, 16'h0007, 16'hFFFD, 16'hFFDB, 16'h0001, 1'b0, 1'b0};
        tv[11] = '{1'b1, 16'hF800, 16'd1,    16'h8000, 16'h0000, 1'b0, 1'b0};
        tv[12] = '{1'b1, 16'h0800, 16'd1,    16'h7FFF, 16'h0000, 1'b0, 1'b1};
        tv[13] = '{1'b0, 16'h0FFF, 16'd1,    16'hFFF0, 16'h0000, 1'b0, 1'b0};
        tv[14] = '{1'b1, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000, 1'b0, 1'b1};
        tv[15] = '{1'b0, 16'd1,    16'd3,    16'd5,    16'd1,    1'b0, 1'b0};

        sclr = 1'b1; start = 1'b0; sm = 1'b0; a = '0; b = '0;
        s_start = 1'b0; s_sm = 1'b0; s_a = '0; s_b = '0;
        tick(); tick();
        chk("reset q", q, 0);
        chk("reset r", r, 0);
        chk("reset dvz", dvz, 0);
        chk("reset ovf", ovf, 0);
        chk("reset busy", busy, 0);
        chk("reset valid", valid, 0);
        sclr = 1'b0;
        tick();

        // Table vectors issued back-to-back: each start lands in the previous valid cycle
        for (int i = 0; i < 16; i++)
            run_op($sformatf("vec%0d", i), tv[i], (i == 0) ? 16'h0000 : tv[i-1].q);

        // Results and flags hold while idle
        tick(); tick(); tick();
        chk("idle hold q", q, 16'd5);
        chk("idle hold r", r, 16'd1);
        chk("idle valid low", valid, 0);

        // Held ovf survives idle cycles
        run_op("ovf_hold_op", tv[2], 16'd5);
        tick(); tick(); tick();
        chk("idle hold ovf", ovf, 1);
        chk("idle hold q_sat", q, 16'hFFFF);

        // Synchronous clear in the middle of an operation
        start = 1'b1; sm = 1'b0; a = 16'd100; b = 16'd8;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        chk("midop busy", busy, 1);
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        chk("sclr busy", busy, 0);
        chk("sclr valid", valid, 0);
        chk("sclr q", q, 0);
        chk("sclr r", r, 0);
        chk("sclr dvz", dvz, 0);
        chk("sclr ovf", ovf, 0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (valid || busy) seen = 1;
        end
        chk("sclr no_valid_after", seen, 0);

        // start while busy is ignored
        start = 1'b1; sm = 1'b0; a = 16'd7; b = 16'd3;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1; a = 16'd100; b = 16'd8;
        tick();
        start = 1'b0;
        lat = 3;
        while (lat < 40) begin
            tick();
            lat++;
            if (valid) break;
        end
        chk("ignored_start latency", lat, N + 1);
        chk("ignored_start q", q, 16'd37);
        chk("ignored_start r", r, 16'd1);

        // start in the valid cycle is accepted
        v = '{1'b1, 16'hFFF9, 16'd3, 16'hFFDB, 16'hFFFF, 1'b0, 1'b0};
        run_op("b2b", v, 16'd37);
        tick();

        // FRAC=0 and FRAC=WIDTH instances against the reference model
        for (int i = 0; i < 40; i++)
            sweep_op(i, 1'($urandom_range(0, 1)), 8'($urandom),
                     (i % 8 == 7) ? 8'h00 : 8'($urandom_range(1, 255)));
        sweep_op(40, 1'b1, 8'h80, 8'hFF);
        sweep_op(41, 1'b0, 8'hFF, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
